regfile_write_port: RTL and testbench

- Write side of the 32-entry, 64-bit LEGv8 register file.
- Accepts write-back requests over a valid/ready handshake and buffers them in a 2-entry in-order queue.
- Retires one queued write per cycle through a 5-to-32 one-hot decoder into the register storage.
- Exposes all 32 register values in parallel on q00..q31, which drive the register file's 32:1 read multiplexers.
- Reports whether a queued write targets a given read address, so issue logic can stall.

---
 rtl/regfile_write_port_pkg.sv | 18 +
 rtl/regfile_write_port_decoder.sv | 20 ++
 rtl/regfile_write_port.sv | 123 ++++++++++++
 tb/tb_regfile_write_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_port_pkg.sv
// Shared constants and helpers for the LEGv8 register file write port.
// Register 31 is XZR: it reads as zero, and writes to it are discarded.
package regfile_write_port_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_WIDTH  = 64;
    localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // A queued write only blocks a reader when it can actually change a register.
    function automatic logic addr_hit(input logic slot_valid, input reg_addr_t slot_addr,
                                      input reg_addr_t probe);
        return slot_valid && (slot_addr == probe) && (probe != XZR_ADDR);
    endfunction

endpackage

// File: rtl/regfile_write_port_decoder.sv
// 5-to-32 one-hot write-enable decoder; XZR and idle cycles produce no enable.
module decoder_5_x_32
    import regfile_write_port_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic                  enable,
    output logic [REG_COUNT-1:0]  onehot
);

    // One-hot decode, suppressed for the zero register.
    always_comb begin
        onehot = '0;
        if (enable && (addr != XZR_ADDR)) begin
            onehot = {{(REG_COUNT-1){1'b0}}, 1'b1} << addr;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32 x n LEGv8 register file: a 2-deep in-order write queue
// retiring one entry per cycle into the register array.
module regfile_write_port
    import regfile_write_port_pkg::*;
#(
    parameter int n = REG_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [n-1:0]          wr_data,
    input  logic                  hold,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rd_pending,
    output logic                  busy,
    output logic [1:0]            count,
    output logic [n-1:0]          q00, q01, q02, q03, q04, q05, q06, q07,
    output logic [n-1:0]          q08, q09, q10, q11, q12, q13, q14, q15,
    output logic [n-1:0]          q16, q17, q18, q19, q20, q21, q22, q23,
    output logic [n-1:0]          q24, q25, q26, q27, q28, q29, q30, q31
);

    // Slot 0 is always the head; the queue shifts down on a pop.
    logic [1:0]     count_r;
    logic [1:0]     count_n_s;
    reg_addr_t      addr_r   [2];
    reg_addr_t      addr_n_s [2];
    logic [n-1:0]   data_r   [2];
    logic [n-1:0]   data_n_s [2];
    logic           push_s;
    logic           pop_s;
    logic [REG_COUNT-1:0] we_s;
    logic [n-1:0]   regs_r [REG_COUNT];

    assign wr_ready = (count_r < 2'd2);
    assign push_s   = wr_valid && wr_ready;
    assign pop_s    = (count_r != 2'd0) && !hold;
    assign busy     = (count_r != 2'd0);
    assign count    = count_r;

    assign rd_pending = addr_hit(count_r != 2'd0, addr_r[0], rd_addr)
                      | addr_hit(count_r == 2'd2, addr_r[1], rd_addr);

    // Next queue contents for every push/pop combination.
    always_comb begin
        addr_n_s  = addr_r;
        data_n_s  = data_r;
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b01: begin
                addr_n_s[0] = addr_r[1];
                data_n_s[0] = data_r[1];
                count_n_s   = count_r - 2'd1;
            end
            2'b10: begin
                if (count_r == 2'd0) begin
                    addr_n_s[0] = wr_addr;
                    data_n_s[0] = wr_data;
                end else begin
                    addr_n_s[1] = wr_addr;
                    data_n_s[1] = wr_data;
                end
                count_n_s = count_r + 2'd1;
            end
            2'b11: begin
                // Only reachable with one entry: the newcomer replaces the retiring head.
                addr_n_s[0] = wr_addr;
                data_n_s[0] = wr_data;
            end
            default: begin
                count_n_s = count_r;
            end
        endcase
    end

    // Queue state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= 2'd0;
            addr_r[0] <= '0;
            addr_r[1] <= '0;
            data_r[0] <= '0;
            data_r[1] <= '0;
        end else begin
            count_r <= count_n_s;
            addr_r  <= addr_n_s;
            data_r  <= data_n_s;
        end
    end

    decoder_5_x_32 u_decoder (
        .addr   (addr_r[0]),
        .enable (pop_s),
        .onehot (we_s)
    );

    // Register storage; entry 31 is never enabled, so it stays at its reset value of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (we_s[i]) begin
                    regs_r[i] <= data_r[0];
                end
            end
        end
    end

    assign q00 = regs_r[0];   assign q01 = regs_r[1];   assign q02 = regs_r[2];   assign q03 = regs_r[3];
    assign q04 = regs_r[4];   assign q05 = regs_r[5];   assign q06 = regs_r[6];   assign q07 = regs_r[7];
    assign q08 = regs_r[8];   assign q09 = regs_r[9];   assign q10 = regs_r[10];  assign q11 = regs_r[11];
    assign q12 = regs_r[12];  assign q13 = regs_r[13];  assign q14 = regs_r[14];  assign q15 = regs_r[15];
    assign q16 = regs_r[16];  assign q17 = regs_r[17];  assign q18 = regs_r[18];  assign q19 = regs_r[19];
    assign q20 = regs_r[20];  assign q21 = regs_r[21];  assign q22 = regs_r[22];  assign q23 = regs_r[23];
    assign q24 = regs_r[24];  assign q25 = regs_r[25];  assign q26 = regs_r[26];  assign q27 = regs_r[27];
    assign q28 = regs_r[28];  assign q29 = regs_r[29];  assign q30 = regs_r[30];  assign q31 = regs_r[31];

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: a pending-write queue plus a register
// array model, checked every cycle, with directed scenarios followed by random traffic.
module tb_regfile_write_port;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_addr = 5'd0;
    logic [63:0] wr_data = 64'd0;
    logic        hold = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    logic        rd_pending;
    logic        busy;
    logic [1:0]  count;
    logic [63:0] q [32];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;

    wr_t         pend[$];
    logic [63:0] mregs [32];

    regfile_write_port #(.n(64)) dut (
        .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold), .rd_addr(rd_addr),
        .rd_pending(rd_pending), .busy(busy), .count(count),
        .q00(q[0]),  .q01(q[1]),  .q02(q[2]),  .q03(q[3]),  .q04(q[4]),  .q05(q[5]),  .q06(q[6]),  .q07(q[7]),
        .q08(q[8]),  .q09(q[9]),  .q10(q[10]), .q11(q[11]), .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
        .q16(q[16]), .q17(q[17]), .q18(q[18]), .q19(q[19]), .q20(q[20]), .q21(q[21]), .q22(q[22]), .q23(q[23]),
        .q24(q[24]), .q25(q[25]), .q26(q[26]), .q27(q[27]), .q28(q[28]), .q29(q[29]), .q30(q[30]), .q31(q[31])
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    endtask

    function automatic logic model_pending(input logic [4:0] ra);
        logic hit;
        hit = 1'b0;
        foreach (pend[k]) if (pend[k].a == ra) hit = 1'b1;
        return hit && (ra != 5'd31);
    endfunction

    // Model advance at each rising edge: the oldest write retires, then a new one may enter.
    initial begin : model_proc
        logic do_pop;
        logic do_push;
        wr_t  e;
        model_clear();
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                model_clear();
            end else begin
                do_pop  = (pend.size() > 0) && !hold;
                do_push = wr_valid && (pend.size() < 2);
                if (do_pop) begin
                    e = pend.pop_front();
                    if (e.a != 5'd31) mregs[e.a] = e.d;
                end
                if (do_push) pend.push_back('{a: wr_addr, d: wr_data});
            end
        end
    end

    // Compare every visible output against the model on the falling edge.
    initial begin : monitor_proc
        forever begin
            @(negedge clock);
            check("count", {62'd0, count}, 64'(pend.size()));
            check("busy", {63'd0, busy}, {63'd0, pend.size() != 0});
            check("wr_ready", {63'd0, wr_ready}, {63'd0, pend.size() < 2});
            check("rd_pending", {63'd0, rd_pending}, {63'd0, model_pending(rd_addr)});
            for (int i = 0; i < 32; i++) check($sformatf("q%02d", i), q[i], mregs[i]);
        end
    end

    // Apply inputs, then advance across one rising edge to just after the next falling edge.
    task automatic step(input logic v, input logic [4:0] a, input logic [63:0] d,
                        input logic h, input logic [4:0] ra);
        wr_valid = v; wr_addr = a; wr_data = d; hold = h; rd_addr = ra;
        @(negedge clock);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        #1;
        check("reset_count", {62'd0, count}, 64'd0);
        check("reset_ready", {63'd0, wr_ready}, 64'd1);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clock); #1;
        @(negedge clock); #1;
        reset_n = 1'b1;
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);

        // Single write: accepted at T, visible after T+1.
        step(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 1'b0, 5'd5);
        check("single_queued", {62'd0, count}, 64'd1);
        check("single_not_yet", q[5], 64'd0);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd5);
        check("single_q05", q[5], 64'hDEAD_BEEF_0123_4567);
        check("single_drained", {62'd0, count}, 64'd0);

        // Back-to-back to the same register under hold.
        step(1'b1, 5'd3, 64'd1, 1'b1, 5'd3);
        step(1'b1, 5'd3, 64'd2, 1'b1, 5'd3);
        wr_valid = 1'b0; #1;
        check("b2b_count", {62'd0, count}, 64'd2);
        check("b2b_ready", {63'd0, wr_ready}, 64'd0);
        check("b2b_pending", {63'd0, rd_pending}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd3);
        check("b2b_first", q[3], 64'd1);
        check("b2b_still_pending", {63'd0, rd_pending}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd3);
        check("b2b_second", q[3], 64'd2);
        check("b2b_pending_clear", {63'd0, rd_pending}, 64'd0);

        // XZR write is popped and dropped.
        step(1'b1, 5'd31, {64{1'b1}}, 1'b0, 5'd31);
        check("xzr_pending", {63'd0, rd_pending}, 64'd0);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd31);
        check("xzr_q31", q[31], 64'd0);
        check("xzr_drained", {62'd0, count}, 64'd0);

        // Full-queue backpressure: third request waits until hold drops.
        step(1'b1, 5'd1, 64'h1111, 1'b1, 5'd4);
        step(1'b1, 5'd2, 64'h2222, 1'b1, 5'd4);
        step(1'b1, 5'd4, 64'h4444, 1'b1, 5'd4);
        check("bp_rejected", {63'd0, rd_pending}, 64'd0);
        step(1'b1, 5'd4, 64'h4444, 1'b0, 5'd4);
        check("bp_first_retired", q[1], 64'h1111);
        step(1'b1, 5'd4, 64'h4444, 1'b0, 5'd4);
        check("bp_third_queued", {63'd0, rd_pending}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd4);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd4);
        check("bp_q02", q[2], 64'h2222);
        check("bp_q04", q[4], 64'h4444);

        // Reset mid-queue discards pending writes, asynchronously.
        step(1'b1, 5'd7, 64'h7777, 1'b1, 5'd7);
        step(1'b1, 5'd8, 64'h8888, 1'b1, 5'd8);
        check("rstq_full", {62'd0, count}, 64'd2);
        wr_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        check("rstq_async_count", {62'd0, count}, 64'd0);
        check("rstq_async_q05", q[5], 64'd0);
        check("rstq_async_ready", {63'd0, wr_ready}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd7);
        reset_n = 1'b1;
        repeat (3) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd7);
        check("rstq_q07", q[7], 64'd0);
        check("rstq_q08", q[8], 64'd0);

        // Random traffic, biased toward a few registers so same-address collisions occur.
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 2) != 0,
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                 {$urandom, $urandom},
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)));
        end
        repeat (4) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        check("final_drained", {62'd0, count}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
